game_speed_ctrl: RTL and testbench
==================================

// Module: game_speed_ctrl
// PURPOSE
//  Run-time controller for the game's timing divider: owns the current division period, produces a
//  one-cycle enable tick every <period> clk cycles and ramps the rate up on game events.
//  Sequences start/pause/stop of game motion and saturates the speed at a floor.
//  Sits between game logic (ball/paddle FSMs, which consume tick) and the system clock.
// PARAMETERS
//  PERIOD_WIDTH  31        width of period and internal counter
//  INIT_PERIOD   50000000  period loaded at reset and on speed_reset (clk cycles per tick)
//  MIN_PERIOD    2         floor for period; speed_up never goes below it
//  STEP          1000000   amount subtracted from period per applied speed_up
//  Legal: INIT_PERIOD >= MIN_PERIOD >= 2; STEP >= 1; all < 2**PERIOD_WIDTH
// PORTS
//  clk          in   1             system clock
//  rst          in   1             asynchronous, active-high reset
//  start        in   1             IDLE -> RUN request (level sampled at posedge)
//  pause        in   1             RUN <-> PAUSED toggle request (one-cycle pulse per toggle)
//  stop         in   1             any state -> IDLE
//  speed_up     in   1             request one STEP decrease of period (pulse)
//  speed_reset  in   1             request period back to INIT_PERIOD (pulse)
//  tick         out  1             one-cycle enable, registered
//  slow_clk     out  1             toggles on every tick (see CONFIGURATION)
//  period       out  PERIOD_WIDTH  current active period
//  state        out  2             00 IDLE, 01 RUN, 10 PAUSED
//  at_max_speed out  1             period == MIN_PERIOD
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, period=INIT_PERIOD, tick=0, slow_clk=0, pending flags=0.
//  Command priority per cycle: stop > pause > start. Ignored: start outside IDLE, pause in IDLE.
//  IDLE: counter held 0, no ticks. start -> RUN with counter=0.
//  RUN: counter +1 per clk; at the edge where counter==period-1: counter<=0, tick<=1 (else tick<=0).
//   Start sampled at edge k -> ticks high after edges k+period, k+2*period, ...
//  PAUSED: counter and tick frozen/low; pause -> RUN resumes counting from held counter value.
//  stop from RUN/PAUSED: -> IDLE, counter=0, tick=0 next cycle; period retained.
//  Period updates:
//   - speed_up sets pending_up; multiple speed_up before application coalesce into one STEP.
//   - speed_reset sets pending_rst and clears pending_up; same-cycle speed_up+speed_reset -> reset wins.
//   - In RUN, pending change applied only at the tick edge (counter wraps), so no partial period.
//   - In IDLE/PAUSED, pending change applied on the next edge (counter value kept in PAUSED;
//     if held counter >= new period-1, next RUN edge wraps: counter<=0, tick<=1).
//   - New period = max(period-STEP, MIN_PERIOD); computed with PERIOD_WIDTH+1 bits, no underflow.
//  at_max_speed combinational from period register. period output = active (not pending) value.
//  Reset mid-operation: immediate return to reset values, pending requests discarded.
// CONFIGURATION
//  GAME_SPEED_SLOWCLK_EN defined: slow_clk register toggles on each tick (50% duty, 2*period cycles
//   per slow_clk cycle) for legacy consumers clocked from a divided clock.
//  Not defined: slow_clk tied 0, no register inferred; all other behaviour identical.
// STRUCTURE
//  Package game_speed_pkg: state enum (IDLE/RUN/PAUSED, 2-bit encoding above), default
//   INIT_PERIOD/MIN_PERIOD/STEP constants, saturating-subtract function.
//  Sub-module period_counter: counter + wrap compare, inputs en/clear/period, output wrap pulse.
//  Top holds FSM, pending flags, period register, tick/slow_clk registers.
// TESTING (bench params: INIT_PERIOD=8, MIN_PERIOD=2, STEP=3, PERIOD_WIDTH=8)
//  1 Reset, start at edge 0 -> tick high after edges 8,16,24; state=01; period=8; slow_clk toggles per tick if EN.
//  2 speed_up pulse at edge 3 -> tick at 8 then period=5 -> ticks at 13,18; second speed_up -> period=2,
//    third -> stays 2, at_max_speed=1.
//  3 pause at edge 5 (counter=4), hold 10 cycles, pause again -> tick 4 cycles after resume; no tick while PAUSED.
//  4 speed_up and speed_reset same cycle from period=2 -> at next tick period=8, no STEP applied.
//  5 stop mid-period -> state=00, tick=0, counter=0, period retained; start -> full period before first tick.
//  6 rst asserted async mid-RUN with pending speed_up -> outputs at reset values immediately; pending lost.

Source files
------------

// File: rtl/game_speed_pkg.sv
// Shared types and defaults for the game speed controller.
// Provides the motion-state encoding and a borrow-safe saturating subtract.
package game_speed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  localparam int unsigned DEF_PERIOD_WIDTH = 31;
  localparam int unsigned DEF_INIT_PERIOD  = 50_000_000;
  localparam int unsigned DEF_MIN_PERIOD   = 2;
  localparam int unsigned DEF_STEP         = 1_000_000;

  // max(value - step, floor); the extra borrow bit keeps a large step from wrapping around.
  function automatic logic [63:0] sat_sub(input logic [63:0] value,
                                          input logic [63:0] step,
                                          input logic [63:0] floor);
    logic [64:0] diff;
    diff = {1'b0, value} - {1'b0, step};
    if (diff[64] || (diff[63:0] < floor)) return floor;
    return diff[63:0];
  endfunction

endpackage

// File: rtl/period_counter.sv
// Free-running period counter: counts while enabled and pulses wrap on the
// cycle whose edge returns the count to zero.
module period_counter
  import game_speed_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    wrap
);

  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] count_q;

  // >= rather than ==: a period shrunk while paused below the held count wraps on the next run edge.
  assign wrap = en && (count_q >= (period - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count_q <= '0;
    else if (clear) count_q <= '0;
    else if (wrap)  count_q <= '0;
    else if (en)    count_q <= count_q + ONE;
  end

endmodule

// File: rtl/game_speed_ctrl.sv
// Game timing divider: IDLE/RUN/PAUSED sequencing, tick generation and period ramping.
// Define GAME_SPEED_SLOWCLK_EN to build the legacy slow_clk toggle register.
module game_speed_ctrl
  import game_speed_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int unsigned INIT_PERIOD  = DEF_INIT_PERIOD,
  parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int unsigned STEP         = DEF_STEP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    stop,
  input  logic                    speed_up,
  input  logic                    speed_reset,
  output logic                    tick,
  output logic                    slow_clk,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic [1:0]              state,
  output logic                    at_max_speed
);

  localparam logic [PERIOD_WIDTH-1:0] INIT_P = PERIOD_WIDTH'(INIT_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P  = PERIOD_WIDTH'(MIN_PERIOD);

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    pend_up_q, pend_up_d;
  logic                    pend_rst_q, pend_rst_d;
  logic                    tick_q;
  logic                    cnt_en, cnt_clear, wrap, apply;

  period_counter #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (cnt_en),
    .clear  (cnt_clear),
    .period (period_q),
    .wrap   (wrap)
  );

  // Command edges themselves never count: pausing/stopping freezes the count on that edge.
  assign cnt_en    = (state_q == ST_RUN) && !stop && !pause;
  assign cnt_clear = (state_q == ST_IDLE) || stop;
  // While running, period changes wait for the wrap so no partial period is ever produced.
  assign apply     = (state_q != ST_RUN) || wrap;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!stop && start) state_d = ST_RUN;
      ST_RUN:    if (stop) state_d = ST_IDLE; else if (pause) state_d = ST_PAUSED;
      ST_PAUSED: if (stop) state_d = ST_IDLE; else if (pause) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    period_d   = period_q;
    pend_up_d  = pend_up_q  && !apply;
    pend_rst_d = pend_rst_q && !apply;
    if (apply) begin
      if (pend_rst_q)
        period_d = INIT_P;
      else if (pend_up_q)
        period_d = PERIOD_WIDTH'(sat_sub(64'(period_q), 64'(STEP), 64'(MIN_PERIOD)));
    end
    // Requests landing on an apply edge are kept for the next application.
    if (speed_reset) begin
      pend_rst_d = 1'b1;
      pend_up_d  = 1'b0;
    end else if (speed_up) begin
      pend_up_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      period_q   <= INIT_P;
      pend_up_q  <= 1'b0;
      pend_rst_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      pend_up_q  <= pend_up_d;
      pend_rst_q <= pend_rst_d;
      tick_q     <= wrap;
    end
  end

`ifdef GAME_SPEED_SLOWCLK_EN
  logic slow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       slow_q <= 1'b0;
    else if (wrap) slow_q <= ~slow_q;
  end

  assign slow_clk = slow_q;
`else
  assign slow_clk = 1'b0;
`endif

  assign tick         = tick_q;
  assign period       = period_q;
  assign state        = state_q;
  assign at_max_speed = (period_q == MIN_P);

endmodule

// File: tb/tb_game_speed_ctrl.sv
// Self-checking bench for game_speed_ctrl: a "cycles left until tick" model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_game_speed_ctrl;

  localparam int PW   = 8;
  localparam int INIT = 8;
  localparam int MINP = 2;
  localparam int STP  = 3;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;

`ifdef GAME_SPEED_SLOWCLK_EN
  localparam bit SLOW_EN = 1'b1;
`else
  localparam bit SLOW_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic          speed_up = 1'b0, speed_reset = 1'b0;
  logic          tick, slow_clk, at_max_speed;
  logic [PW-1:0] period;
  logic [1:0]    state;

  int checks   = 0;
  int failures = 0;

  game_speed_ctrl #(
    .PERIOD_WIDTH (PW),
    .INIT_PERIOD  (INIT),
    .MIN_PERIOD   (MINP),
    .STEP         (STP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pause        (pause),
    .stop         (stop),
    .speed_up     (speed_up),
    .speed_reset  (speed_reset),
    .tick         (tick),
    .slow_clk     (slow_clk),
    .period       (period),
    .state        (state),
    .at_max_speed (at_max_speed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode, run edges left before the next tick, active period, pending requests.
  int m_mode, m_left, m_per, m_newp;
  bit m_pu, m_pr, m_tick, m_slow, m_apply;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_left = 0; m_per = INIT;
      m_pu = 0; m_pr = 0; m_tick = 0; m_slow = 0;
    end else begin
      m_apply = 0;
      m_tick  = 0;
      if (m_pr)      m_newp = INIT;
      else if (m_pu) m_newp = (m_per - STP < MINP) ? MINP : m_per - STP;
      else           m_newp = m_per;
      case (m_mode)
        M_IDLE: begin
          m_apply = 1;
          if (!stop && start) begin m_mode = M_RUN; m_left = m_newp; end
        end
        M_RUN: begin
          if (stop) m_mode = M_IDLE;
          else if (pause) m_mode = M_PAUSED;
          else begin
            m_left--;
            if (m_left == 0) begin m_tick = 1; m_apply = 1; m_left = m_newp; end
          end
        end
        default: begin
          m_apply = 1;
          // Cycles already run stay spent; a shorter period may leave only the wrap edge.
          m_left = m_newp - (m_per - m_left);
          if (m_left < 1) m_left = 1;
          if (stop) m_mode = M_IDLE;
          else if (pause) m_mode = M_RUN;
        end
      endcase
      if (m_tick && SLOW_EN) m_slow = !m_slow;
      if (m_apply) begin m_per = m_newp; m_pu = 0; m_pr = 0; end
      if (speed_reset) begin m_pr = 1; m_pu = 0; end
      else if (speed_up) m_pu = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_tick",   32'(tick),         32'(m_tick));
      check("cyc_state",  32'(state),        32'(m_mode));
      check("cyc_period", 32'(period),       32'(m_per));
      check("cyc_atmax",  32'(at_max_speed), 32'(m_per == MINP));
      check("cyc_slow",   32'(slow_clk),     32'(m_slow));
    end
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go(2);
    rst = 1'b0;
    go(1);
  endtask

  initial begin
    // 1: reset values, start, ticks after edges 8/16/24
    do_reset();
    check("rst_state", 32'(state), 0);
    check("rst_period", 32'(period), 8);
    check("rst_tick", 32'(tick), 0);
    check("rst_atmax", 32'(at_max_speed), 0);
    check("rst_slow", 32'(slow_clk), 0);
    start = 1; go(1); start = 0;
    check("s1_state_run", 32'(state), 1);
    go(7); check("s1_tick_e7", 32'(tick), 0);
    go(1); check("s1_tick_e8", 32'(tick), 1);
    check("s1_slow_e8", 32'(slow_clk), 32'(SLOW_EN));
    go(1); check("s1_tick_e9", 32'(tick), 0);
    go(7); check("s1_tick_e16", 32'(tick), 1);
    go(8); check("s1_tick_e24", 32'(tick), 1);
    check("s1_slow_e24", 32'(slow_clk), 32'(SLOW_EN));

    // 2 + 4: speed_up ramp to the floor, then combined speed_up/speed_reset
    do_reset();
    start = 1; go(1); start = 0;
    go(2); speed_up = 1; go(1); speed_up = 0;
    go(4); check("s2_period_e7", 32'(period), 8);
    go(1); check("s2_tick_e8", 32'(tick), 1);
    check("s2_period_e8", 32'(period), 5);
    go(5); check("s2_tick_e13", 32'(tick), 1);
    speed_up = 1; go(1); speed_up = 0;
    go(4); check("s2_tick_e18", 32'(tick), 1);
    check("s2_period_e18", 32'(period), 2);
    check("s2_atmax_e18", 32'(at_max_speed), 1);
    speed_up = 1; go(1); speed_up = 0;
    go(1); check("s2_tick_e20", 32'(tick), 1);
    check("s2_period_floor", 32'(period), 2);
    speed_up = 1; speed_reset = 1; go(1); speed_up = 0; speed_reset = 0;
    check("s4_period_pending", 32'(period), 2);
    go(1); check("s4_tick_e22", 32'(tick), 1);
    check("s4_period_init", 32'(period), 8);
    check("s4_atmax_off", 32'(at_max_speed), 0);
    go(8); check("s4_tick_e30", 32'(tick), 1);

    // 3: pause with counter=4, hold, resume -> tick 4 edges later
    do_reset();
    start = 1; go(1); start = 0;
    go(4); pause = 1; go(1); pause = 0;
    go(10); check("s3_state_paused", 32'(state), 2);
    pause = 1; go(1); pause = 0;
    check("s3_state_resumed", 32'(state), 1);
    go(3); check("s3_tick_r3", 32'(tick), 0);
    go(1); check("s3_tick_r4", 32'(tick), 1);

    // 5: period change in IDLE, stop mid-period, restart gets a full period
    do_reset();
    speed_up = 1; go(1); speed_up = 0;
    go(1); check("s5_period_idle", 32'(period), 5);
    start = 1; go(1); start = 0;
    go(3); stop = 1; go(1); stop = 0;
    check("s5_state_idle", 32'(state), 0);
    check("s5_tick_stop", 32'(tick), 0);
    check("s5_period_kept", 32'(period), 5);
    go(2);
    start = 1; go(1); start = 0;
    go(4); check("s5_tick_e4", 32'(tick), 0);
    go(1); check("s5_tick_e5", 32'(tick), 1);

    // 6: async reset mid-RUN drops the pending speed_up
    do_reset();
    speed_up = 1; go(1); speed_up = 0;
    go(1); check("s6_period_pre", 32'(period), 5);
    start = 1; go(1); start = 0;
    go(2); speed_up = 1; go(1); speed_up = 0;
    #3 rst = 1'b1;
    #1;
    check("s6_async_state", 32'(state), 0);
    check("s6_async_period", 32'(period), 8);
    check("s6_async_tick", 32'(tick), 0);
    check("s6_async_atmax", 32'(at_max_speed), 0);
    go(1); rst = 1'b0;
    go(1);
    start = 1; go(1); start = 0;
    go(7); check("s6_tick_e7", 32'(tick), 0);
    go(1); check("s6_tick_e8", 32'(tick), 1);
    check("s6_period_no_step", 32'(period), 8);
    go(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
